// File: rtl/l2_input_arbiter_pkg.sv
// l2_input_arbiter_pkg: shared types for the L2 ingress arbiter.
// Holds the arbitration kind encoding, the default starvation limit and the
// message payload structs carried through the arbiter without decoding.
package l2_input_arbiter_pkg;

  // Which channel currently owns the output stage
  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_RSP  = 2'd1,
    ARB_FWD  = 2'd2,
    ARB_CPU  = 2'd3
  } arb_kind_t;

  // Consecutive lost arbitration cycles before a held CPU request is promoted
  localparam int L2_ARB_STARVE_MAX = 8;

  // Response arriving from the NoC (data or ack for an outstanding request)
  typedef struct packed {
    logic [1:0]  coh_msg;
    logic [31:0] addr;
    logic [31:0] line_word;
  } l2_rsp_in_t;

  // Forwarded coherence request from the directory
  typedef struct packed {
    logic [2:0]  coh_msg;
    logic [3:0]  req_id;
    logic [31:0] addr;
    logic [31:0] line_word;
  } l2_fwd_in_t;

  // Request from the local CPU / L1
  typedef struct packed {
    logic [1:0]  cpu_msg;
    logic [2:0]  hsize;
    logic [1:0]  hprot;
    logic [31:0] addr;
    logic [31:0] word;
  } l2_cpu_req_t;

endpackage

// File: rtl/l2_skid_hold.sv
// l2_skid_hold: one-entry valid/ready hold register for one ingress channel.
// The entry may be refilled on the same edge that the arbiter takes the old
// contents, so a selected channel keeps full throughput.
module l2_skid_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         sel,
  output logic         hold_v,
  output logic [W-1:0] hold_data
);

  logic         hold_v_reg;
  logic [W-1:0] hold_data_reg;

  // Room exists when empty or when the current entry leaves this cycle
  assign in_ready  = !hold_v_reg || sel;
  assign hold_v    = hold_v_reg;
  assign hold_data = hold_data_reg;

  // Capture a new message, or drop the entry once the arbiter has taken it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v_reg    <= 1'b0;
      hold_data_reg <= '0;
    end else if (in_valid && in_ready) begin
      hold_v_reg    <= 1'b1;
      hold_data_reg <= in_data;
    end else if (sel) begin
      hold_v_reg    <= 1'b0;
    end
  end

endmodule

// File: rtl/l2_input_arbiter.sv
// l2_input_arbiter: ingress stage of the Spandex L2.
// Buffers one response, one forward and one CPU request, picks one per cycle
// (RSP > FWD > CPU, a stalled FWD is skipped) and registers the winner into a
// single valid/ready output stage.
// Optional feature macro: L2_ARB_ANTI_STARVE_EN -- when defined, a CPU
// request that keeps losing is promoted above FWD after STARVE_MAX losses
// (never above RSP, which must always drain first for deadlock freedom).
module l2_input_arbiter
  import l2_input_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = L2_ARB_STARVE_MAX,
  parameter int STARVE_W   = $clog2(STARVE_MAX + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        l2_rsp_in_valid,
  output logic        l2_rsp_in_ready,
  input  l2_rsp_in_t  l2_rsp_in,
  input  logic        l2_fwd_in_valid,
  output logic        l2_fwd_in_ready,
  input  l2_fwd_in_t  l2_fwd_in,
  input  logic        l2_cpu_req_valid,
  output logic        l2_cpu_req_ready,
  input  l2_cpu_req_t l2_cpu_req,
  input  logic        fwd_stall,
  output logic        out_valid,
  input  logic        out_ready,
  output arb_kind_t   out_kind,
  output l2_rsp_in_t  out_rsp,
  output l2_fwd_in_t  out_fwd,
  output l2_cpu_req_t out_cpu
);

  logic        rsp_hold_v, fwd_hold_v, cpu_hold_v;
  l2_rsp_in_t  rsp_hold;
  l2_fwd_in_t  fwd_hold;
  l2_cpu_req_t cpu_hold;
  logic        rsp_sel, fwd_sel, cpu_sel;
  arb_kind_t   sel_kind;
  logic        ld;
  logic        cpu_promote;

  logic        out_valid_reg;
  arb_kind_t   out_kind_reg;
  l2_rsp_in_t  out_rsp_reg;
  l2_fwd_in_t  out_fwd_reg;
  l2_cpu_req_t out_cpu_reg;

  l2_skid_hold #(.W($bits(l2_rsp_in_t))) u_rsp_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (l2_rsp_in_valid),
    .in_ready  (l2_rsp_in_ready),
    .in_data   (l2_rsp_in),
    .sel       (rsp_sel),
    .hold_v    (rsp_hold_v),
    .hold_data (rsp_hold)
  );

  l2_skid_hold #(.W($bits(l2_fwd_in_t))) u_fwd_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (l2_fwd_in_valid),
    .in_ready  (l2_fwd_in_ready),
    .in_data   (l2_fwd_in),
    .sel       (fwd_sel),
    .hold_v    (fwd_hold_v),
    .hold_data (fwd_hold)
  );

  l2_skid_hold #(.W($bits(l2_cpu_req_t))) u_cpu_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (l2_cpu_req_valid),
    .in_ready  (l2_cpu_req_ready),
    .in_data   (l2_cpu_req),
    .sel       (cpu_sel),
    .hold_v    (cpu_hold_v),
    .hold_data (cpu_hold)
  );

  // The output stage can take a new message when empty or being drained
  assign ld = !out_valid_reg || out_ready;

`ifdef L2_ARB_ANTI_STARVE_EN
  logic [STARVE_W-1:0] starve_cnt_reg;

  assign cpu_promote = (starve_cnt_reg == STARVE_W'(STARVE_MAX));

  // Count selection cycles a held CPU request loses; reset when it wins or leaves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
    end else if (!cpu_hold_v || cpu_sel) begin
      starve_cnt_reg <= '0;
    end else if (ld && !cpu_promote) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end
`else
  // Starvation parameters are accepted for interface compatibility only
  logic [31:0] unused_starve_cfg;
  assign unused_starve_cfg = 32'(STARVE_MAX + STARVE_W);
  assign cpu_promote = 1'b0;
`endif

  // Fixed-priority pick; only evaluated when the output stage can load
  always_comb begin
    rsp_sel  = 1'b0;
    fwd_sel  = 1'b0;
    cpu_sel  = 1'b0;
    sel_kind = ARB_NONE;
    if (ld) begin
      if (rsp_hold_v) begin
        rsp_sel  = 1'b1;
        sel_kind = ARB_RSP;
      end else if (cpu_hold_v && cpu_promote) begin
        cpu_sel  = 1'b1;
        sel_kind = ARB_CPU;
      end else if (fwd_hold_v && !fwd_stall) begin
        fwd_sel  = 1'b1;
        sel_kind = ARB_FWD;
      end else if (cpu_hold_v) begin
        cpu_sel  = 1'b1;
        sel_kind = ARB_CPU;
      end
    end
  end

  // Register the winner; unselected payload groups keep their last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_kind_reg  <= ARB_NONE;
      out_rsp_reg   <= '0;
      out_fwd_reg   <= '0;
      out_cpu_reg   <= '0;
    end else if (ld) begin
      out_valid_reg <= (sel_kind != ARB_NONE);
      out_kind_reg  <= sel_kind;
      if (rsp_sel) out_rsp_reg <= rsp_hold;
      if (fwd_sel) out_fwd_reg <= fwd_hold;
      if (cpu_sel) out_cpu_reg <= cpu_hold;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_kind  = out_kind_reg;
  assign out_rsp   = out_rsp_reg;
  assign out_fwd   = out_fwd_reg;
  assign out_cpu   = out_cpu_reg;

endmodule

// File: tb/tb_l2_input_arbiter.sv
// tb_l2_input_arbiter: directed bench with a transaction-level reference model
// and a per-channel delivery scoreboard for l2_input_arbiter.
`timescale 1ns/1ps
module tb_l2_input_arbiter;
  import l2_input_arbiter_pkg::*;

  localparam int SMAX = 4;
  localparam int RW = $bits(l2_rsp_in_t);
  localparam int FW = $bits(l2_fwd_in_t);
  localparam int CW = $bits(l2_cpu_req_t);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        l2_rsp_in_valid, l2_rsp_in_ready;
  l2_rsp_in_t  l2_rsp_in;
  logic        l2_fwd_in_valid, l2_fwd_in_ready;
  l2_fwd_in_t  l2_fwd_in;
  logic        l2_cpu_req_valid, l2_cpu_req_ready;
  l2_cpu_req_t l2_cpu_req;
  logic        fwd_stall, out_valid, out_ready;
  logic [1:0]  out_kind;
  l2_rsp_in_t  out_rsp;
  l2_fwd_in_t  out_fwd;
  l2_cpu_req_t out_cpu;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  l2_input_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .l2_rsp_in_valid  (l2_rsp_in_valid),
    .l2_rsp_in_ready  (l2_rsp_in_ready),
    .l2_rsp_in        (l2_rsp_in),
    .l2_fwd_in_valid  (l2_fwd_in_valid),
    .l2_fwd_in_ready  (l2_fwd_in_ready),
    .l2_fwd_in        (l2_fwd_in),
    .l2_cpu_req_valid (l2_cpu_req_valid),
    .l2_cpu_req_ready (l2_cpu_req_ready),
    .l2_cpu_req       (l2_cpu_req),
    .fwd_stall        (fwd_stall),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_kind         (out_kind),
    .out_rsp          (out_rsp),
    .out_fwd          (out_fwd),
    .out_cpu          (out_cpu)
  );

  // Zero-extended views so all channels compare on one width
  wire [127:0] in_rsp_w  = {{(128-RW){1'b0}}, l2_rsp_in};
  wire [127:0] in_fwd_w  = {{(128-FW){1'b0}}, l2_fwd_in};
  wire [127:0] in_cpu_w  = {{(128-CW){1'b0}}, l2_cpu_req};
  wire [127:0] out_rsp_w = {{(128-RW){1'b0}}, out_rsp};
  wire [127:0] out_fwd_w = {{(128-FW){1'b0}}, out_fwd};
  wire [127:0] out_cpu_w = {{(128-CW){1'b0}}, out_cpu};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Message content: channel tag and sequence number, fits every payload width
  function automatic logic [127:0] msg(input int ch, input int n);
    logic [127:0] v;
    v = '0;
    v[63:0] = {8'(ch + 1), 24'(n), 16'hC0DE, 16'(n * 7 + ch)};
    return v;
  endfunction

  function automatic bit vld(input int ch);
    case (ch)
      0: return l2_rsp_in_valid;
      1: return l2_fwd_in_valid;
      default: return l2_cpu_req_valid;
    endcase
  endfunction

  function automatic logic [127:0] in_of(input int ch);
    case (ch)
      0: return in_rsp_w;
      1: return in_fwd_w;
      default: return in_cpu_w;
    endcase
  endfunction

  function automatic logic [127:0] out_of(input int ch);
    case (ch)
      0: return out_rsp_w;
      1: return out_fwd_w;
      default: return out_cpu_w;
    endcase
  endfunction

  // ---------------- reference model (channel 0=RSP, 1=FWD, 2=CPU) ----------
  logic [2:0]        m_v;
  logic [2:0][127:0] m_d;
  logic [2:0][127:0] m_pay;
  logic              m_ov;
  int                m_kind;
  int                m_starve;
  logic [127:0]      acc_q0[$], acc_q1[$], acc_q2[$];
  int                deliv_log[$];

  // Highest-ranked eligible hold, or -1; CPU moves ahead of FWD once starved
  function automatic int pick(input bit stall);
    int order[3];
    order[0] = 0; order[1] = 1; order[2] = 2;
`ifdef L2_ARB_ANTI_STARVE_EN
    if (m_starve >= SMAX) begin order[1] = 2; order[2] = 1; end
`endif
    for (int i = 0; i < 3; i++)
      if (m_v[order[i]] && !(order[i] == 1 && stall)) return order[i];
    return -1;
  endfunction

  task automatic acc_push(input int ch, input logic [127:0] d);
    case (ch)
      0: acc_q0.push_back(d);
      1: acc_q1.push_back(d);
      default: acc_q2.push_back(d);
    endcase
  endtask

  task automatic acc_pop(input int ch, output logic [127:0] d, output bit ok);
    ok = 1'b0; d = '0;
    case (ch)
      0: if (acc_q0.size() != 0) begin d = acc_q0.pop_front(); ok = 1'b1; end
      1: if (acc_q1.size() != 0) begin d = acc_q1.pop_front(); ok = 1'b1; end
      default: if (acc_q2.size() != 0) begin d = acc_q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Advance the model one clock edge; reset drops everything in flight
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v <= '0; m_d <= '0; m_pay <= '0;
      m_ov <= 1'b0; m_kind <= 0; m_starve <= 0;
      acc_q0.delete(); acc_q1.delete(); acc_q2.delete();
    end else begin
      bit ld_t;
      int w_t;
      ld_t = !m_ov || out_ready;
      w_t  = ld_t ? pick(fwd_stall) : -1;
      if (ld_t) begin
        m_ov   <= (w_t >= 0);
        m_kind <= w_t + 1;
        if (w_t >= 0) m_pay[w_t] <= m_d[w_t];
      end
      if (!m_v[2] || w_t == 2) m_starve <= 0;
      else if (ld_t) m_starve <= (m_starve < SMAX) ? m_starve + 1 : SMAX;
      for (int c = 0; c < 3; c++) begin
        if (vld(c) && (!m_v[c] || w_t == c)) begin
          m_v[c] <= 1'b1;
          m_d[c] <= in_of(c);
          acc_push(c, in_of(c));
        end else if (w_t == c) begin
          m_v[c] <= 1'b0;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, and score each delivery
  always @(negedge clk) begin
    if (rst_n) begin
      bit ld_c;
      int w_c;
      int k;
      logic [127:0] exp_d;
      bit ok;
      ld_c = !m_ov || out_ready;
      w_c  = ld_c ? pick(fwd_stall) : -1;
      check("rsp_ready", l2_rsp_in_ready,  !m_v[0] || w_c == 0);
      check("fwd_ready", l2_fwd_in_ready,  !m_v[1] || w_c == 1);
      check("cpu_ready", l2_cpu_req_ready, !m_v[2] || w_c == 2);
      check("out_valid", out_valid, m_ov);
      check("out_kind", out_kind, m_kind);
      if (m_ov && m_kind > 0) check("out_payload", out_of(m_kind - 1), m_pay[m_kind - 1]);
      if (out_valid && out_ready) begin
        k = int'(out_kind);
        deliv_log.push_back(k);
        if (k == 0) begin
          check("deliver_kind_nonzero", 128'(k), 128'(1));
        end else begin
          acc_pop(k - 1, exp_d, ok);
          check("deliver_expected", 128'(ok), 128'(1));
          if (ok) check("deliver_payload", out_of(k - 1), exp_d);
        end
      end
    end
  end

  // ---------------- upstream senders ----------------
  logic [127:0] tx_q0[$], tx_q1[$], tx_q2[$];

  task automatic refresh();
    l2_rsp_in_valid  = (tx_q0.size() != 0);
    l2_fwd_in_valid  = (tx_q1.size() != 0);
    l2_cpu_req_valid = (tx_q2.size() != 0);
    if (tx_q0.size() != 0) l2_rsp_in  = tx_q0[0][RW-1:0];
    if (tx_q1.size() != 0) l2_fwd_in  = tx_q1[0][FW-1:0];
    if (tx_q2.size() != 0) l2_cpu_req = tx_q2[0][CW-1:0];
  endtask

  task automatic push(input int ch, input int n);
    case (ch)
      0: tx_q0.push_back(msg(0, n));
      1: tx_q1.push_back(msg(1, n));
      default: tx_q2.push_back(msg(2, n));
    endcase
  endtask

  // Retire accepted messages and present the next ones
  initial begin
    bit hs0, hs1, hs2;
    forever begin
      @(negedge clk);
      hs0 = l2_rsp_in_valid && l2_rsp_in_ready;
      hs1 = l2_fwd_in_valid && l2_fwd_in_ready;
      hs2 = l2_cpu_req_valid && l2_cpu_req_ready;
      @(posedge clk);
      #1;
      if (hs0 && tx_q0.size() != 0) void'(tx_q0.pop_front());
      if (hs1 && tx_q1.size() != 0) void'(tx_q1.pop_front());
      if (hs2 && tx_q2.size() != 0) void'(tx_q2.pop_front());
      refresh();
    end
  end

  task automatic at_edge();
    @(posedge clk);
    #2;
  endtask

  function automatic int first_cpu();
    foreach (deliv_log[i]) if (deliv_log[i] == 3) return i;
    return -1;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int exp_seq[6];
    l2_rsp_in_valid = 0; l2_fwd_in_valid = 0; l2_cpu_req_valid = 0;
    l2_rsp_in = '0; l2_fwd_in = '0; l2_cpu_req = '0;
    fwd_stall = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle after reset
    @(negedge clk);
    check("idle_rsp_ready", l2_rsp_in_ready, 1);
    check("idle_fwd_ready", l2_fwd_in_ready, 1);
    check("idle_cpu_ready", l2_cpu_req_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_out_kind", out_kind, 0);

    // All three at once: 1,2,3 on consecutive cycles
    at_edge();
    push(0, 1); push(1, 1); push(2, 1); refresh();
    @(posedge clk);
    @(negedge clk); check("simul_lat_valid", out_valid, 0);
    @(negedge clk); check("simul_k1", out_kind, 1); check("simul_p1", out_rsp_w, msg(0, 1));
    @(negedge clk); check("simul_k2", out_kind, 2); check("simul_p2", out_fwd_w, msg(1, 1));
    @(negedge clk); check("simul_k3", out_kind, 3); check("simul_p3", out_cpu_w, msg(2, 1));
    @(negedge clk); check("simul_empty", out_valid, 0);

    // Stalled FWD does not block CPU; FWD goes right after the stall drops
    at_edge();
    fwd_stall = 1; push(1, 2); push(2, 2); refresh();
    @(posedge clk);
    @(negedge clk); check("stall_lat_valid", out_valid, 0);
    @(negedge clk); check("stall_cpu_first", out_kind, 3); check("stall_cpu_pay", out_cpu_w, msg(2, 2));
    at_edge();
    fwd_stall = 0;
    @(negedge clk); check("stall_gap_valid", out_valid, 0);
    @(negedge clk); check("stall_fwd_after", out_kind, 2); check("stall_fwd_pay", out_fwd_w, msg(1, 2));

    // Backpressure: holds fill, output stays stable, nothing lost on release
    at_edge();
    deliv_log.delete();
    out_ready = 0;
    push(0, 3); push(0, 4); push(1, 3); push(1, 4); push(2, 3); push(2, 4); refresh();
    @(posedge clk);
    @(negedge clk); check("bp_lat_valid", out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_kind", out_kind, 1);
      check("bp_pay", out_rsp_w, msg(0, 3));
      check("bp_rsp_ready", l2_rsp_in_ready, 0);
      check("bp_fwd_ready", l2_fwd_in_ready, 0);
      check("bp_cpu_ready", l2_cpu_req_ready, 0);
    end
    at_edge();
    out_ready = 1;
    repeat (10) @(posedge clk);
    exp_seq = '{1, 1, 2, 2, 3, 3};
    check("bp_count", 128'(deliv_log.size()), 128'(6));
    for (int i = 0; i < 6 && i < deliv_log.size(); i++) check("bp_order", 128'(deliv_log[i]), 128'(exp_seq[i]));

    // Back-to-back FWD with one CPU request held, run twice
    for (int r = 0; r < 2; r++) begin
      at_edge();
      deliv_log.delete();
      push(2, 10 + r * 10);
      for (int i = 0; i < 8; i++) push(1, 10 + r * 10 + i);
      refresh();
      repeat (14) @(posedge clk);
      check("starve_count", 128'(deliv_log.size()), 128'(9));
`ifdef L2_ARB_ANTI_STARVE_EN
      check("starve_cpu_pos", 128'(first_cpu()), 128'(4));
`else
      check("starve_cpu_pos", 128'(first_cpu()), 128'(8));
`endif
    end

    // Mixed traffic under a stall / out_ready pattern table
    at_edge();
    for (int i = 0; i < 4; i++) begin push(0, 40 + i); push(1, 40 + i); push(2, 40 + i); end
    refresh();
    for (int i = 0; i < 16; i++) begin
      logic [15:0] stall_pat, rdy_pat;
      stall_pat = 16'b0011_0110_1100_1010;
      rdy_pat   = 16'b1101_1011_0111_1110;
      at_edge();
      fwd_stall = stall_pat[i];
      out_ready = rdy_pat[i];
    end
    at_edge();
    fwd_stall = 0; out_ready = 1;
    repeat (16) @(posedge clk);
    check("mix_drained_rsp", 128'(acc_q0.size()), 128'(0));
    check("mix_drained_fwd", 128'(acc_q1.size()), 128'(0));
    check("mix_drained_cpu", 128'(acc_q2.size()), 128'(0));

    // Asynchronous reset with every hold full
    at_edge();
    out_ready = 0;
    push(0, 60); push(0, 61); push(1, 60); push(1, 61); push(2, 60); push(2, 61); refresh();
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    tx_q0.delete(); tx_q1.delete(); tx_q2.delete(); refresh();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_kind", out_kind, 0);
    check("rst_rsp_ready", l2_rsp_in_ready, 1);
    check("rst_fwd_ready", l2_fwd_in_ready, 1);
    check("rst_cpu_ready", l2_cpu_req_ready, 1);
    check("rst_out_rsp", out_rsp_w, 0);
    check("rst_out_fwd", out_fwd_w, 0);
    check("rst_out_cpu", out_cpu_w, 0);
    at_edge();
    rst_n = 1'b1; out_ready = 1;

    // Traffic after reset
    at_edge();
    push(0, 70); push(1, 70); push(2, 70); refresh();
    repeat (8) @(posedge clk);
    check("post_rst_rsp", out_rsp_w, msg(0, 70));
    check("post_rst_cpu", out_cpu_w, msg(2, 70));
    check("end_tx_empty", 128'(tx_q0.size() + tx_q1.size() + tx_q2.size()), 128'(0));
    check("end_acc_empty", 128'(acc_q0.size() + acc_q1.size() + acc_q2.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
